// File: rtl/seg7_scan_display_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_display_if
// Bundles the value/handshake inputs and the display-pin outputs of
// seg7_scan_display.
//   value               binary number to display (IN_WIDTH bits)
//   value_load          capture request, honoured only while busy==0
//   busy                conversion in progress
//   blank_leading_zeros live control: suppress leading zeros
//   dp_mask             live control: bit k lights the dp of digit k
//   overflow            committed value does not fit in NUM_DIGITS digits
//   anode_activate      active-low digit selects, bit k = 10^k digit
//   LED_out             active-low {a,b,c,d,e,f,g,dp}
// master = score/game logic side, slave = the display driver.
// ---------------------------------------------------------------------------
interface seg7_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IN_WIDTH   = 16
);
  logic [IN_WIDTH-1:0]   value;
  logic                  value_load;
  logic                  busy;
  logic                  blank_leading_zeros;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic                  overflow;
  logic [NUM_DIGITS-1:0] anode_activate;
  logic [7:0]            LED_out;

  modport master (
    output value, value_load, blank_leading_zeros, dp_mask,
    input  busy, overflow, anode_activate, LED_out
  );

  modport slave (
    input  value, value_load, blank_leading_zeros, dp_mask,
    output busy, overflow, anode_activate, LED_out
  );
endinterface

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
// Multiplexed common-anode 7-segment driver. A captured binary value is
// converted to BCD by an iterative double-dabble engine (one bit per clock),
// committed to a display register, and scanned MSD first across NUM_DIGITS
// digits with an all-off blanking window at every digit switch.
// Ports:
//   clock_100Mhz  system clock
//   reset         asynchronous, active-low
//   bus           seg7_scan_display_if.slave (value/load/busy, live display
//                 controls, overflow flag, anode and cathode pins)
// ---------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int IN_WIDTH     = 16,
  parameter int REFRESH_DIV  = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic                clock_100Mhz,
  input  logic                reset,
  seg7_scan_display_if.slave  bus
);

  localparam int CONV_MIN    = IN_WIDTH * 3 / 10 + 1;
  localparam int CONV_DIGITS = (NUM_DIGITS > CONV_MIN) ? NUM_DIGITS : CONV_MIN;
  localparam int BCD_W       = 4 * CONV_DIGITS;
  localparam int DISP_W      = 4 * NUM_DIGITS;
  localparam int CNT_W       = $clog2(IN_WIDTH);
  localparam int PRE_W       = $clog2(REFRESH_DIV);
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(IN_WIDTH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic               load_en, shift_en, commit_en;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [IN_WIDTH-1:0] bin_sr_q;
  logic [BCD_W-1:0]   bcd_q, bcd_adj, bcd_shift;
  logic [DISP_W-1:0]  disp_q;
  logic               ovf_q;
  logic               high_nz;

  logic [PRE_W-1:0]      pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_DIGITS:0]   zero_from;
  logic [3:0]            cur_digit;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] anode_p0, anode_p1;
  logic [7:0]            led_p0, led_p1;

  // Conversion control
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_en)
        bit_cnt_q <= '0;
      else if (shift_en)
        bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.value_load) begin
          load_en = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt_q == CNT_LAST)
          state_d = S_COMMIT;
      end
      S_COMMIT: begin
        commit_en = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Double-dabble step: correct every nibble >= 5, then shift in the next bit
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < CONV_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_shift = (bcd_adj << 1) | BCD_W'(bin_sr_q[IN_WIDTH-1]);

  always_ff @(posedge clock_100Mhz) begin
    if (load_en) begin
      bin_sr_q <= bus.value;
      bcd_q    <= '0;
    end else if (shift_en) begin
      bin_sr_q <= bin_sr_q << 1;
      bcd_q    <= bcd_shift;
    end
  end

  // Digits beyond the visible ones only exist when the input can exceed them
  if (CONV_DIGITS > NUM_DIGITS) begin : g_high
    assign high_nz = |bcd_q[BCD_W-1:DISP_W];
  end else begin : g_no_high
    assign high_nz = 1'b0;
  end

  // Commit: whole display register replaced in one cycle, so no tearing
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (commit_en) begin
      disp_q <= bcd_q[DISP_W-1:0];
      ovf_q  <= high_nz;
    end
  end

  // Scan stage p0: select digit and build pin pattern from prescaler/index
  always_comb begin
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--)
      zero_from[k] = zero_from[k+1] & (disp_q[4*k +: 4] == 4'd0);

    cur_digit = disp_q[idx_q*4 +: 4];
    if (ovf_q)
      seg = 7'b1111110;
    else if (bus.blank_leading_zeros && (idx_q != '0) && zero_from[idx_q])
      seg = 7'b1111111;
    else
      seg = seg_decode(cur_digit);

    anode_p0 = ~(NUM_DIGITS'(1) << idx_q);
    led_p0   = {seg, ~bus.dp_mask[idx_q]};
    if (pre_q < PRE_BLANK) begin
      anode_p0 = '1;
      led_p0   = 8'hFF;
    end
  end

  // Scan stage p1: registered pins; prescaler and MSD-first index advance
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      pre_q    <= '0;
      idx_q    <= IDX_LAST;
      anode_p1 <= '1;
      led_p1   <= 8'hFF;
    end else begin
      anode_p1 <= anode_p0;
      led_p1   <= led_p0;
      if (pre_q == PRE_LAST) begin
        pre_q <= '0;
        idx_q <= (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.overflow       = ovf_q;
  assign bus.anode_activate = anode_p1;
  assign bus.LED_out        = led_p1;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
// Two instances: A (4 digits, 16-bit input, short refresh) for the main
// behaviour, B (8 digits, 27-bit input, REFRESH_DIV=8, BLANK_CYCLES=2).
// Expected pin values come from decimal arithmetic on the loaded value.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;
  localparam int AN = 4, AW = 16, ARD = 16, ABC = 4;
  localparam int BN = 8, BW = 27, BRD = 8,  BBC = 2;

  logic clock_100Mhz = 1'b0;
  logic reset = 1'b1;
  always #5 clock_100Mhz = ~clock_100Mhz;

  seg7_scan_display_if #(.NUM_DIGITS(AN), .IN_WIDTH(AW)) ia ();
  seg7_scan_display_if #(.NUM_DIGITS(BN), .IN_WIDTH(BW)) ib ();

  seg7_scan_display #(.NUM_DIGITS(AN), .IN_WIDTH(AW), .REFRESH_DIV(ARD), .BLANK_CYCLES(ABC))
    dut_a (.clock_100Mhz(clock_100Mhz), .reset(reset), .bus(ia));
  seg7_scan_display #(.NUM_DIGITS(BN), .IN_WIDTH(BW), .REFRESH_DIV(BRD), .BLANK_CYCLES(BBC))
    dut_b (.clock_100Mhz(clock_100Mhz), .reset(reset), .bus(ib));

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;
  bit cfg_blz = 1'b0;
  logic [7:0] cfg_dpm = 8'h00;

  logic [7:0] cur_an, cur_led;
  logic       cur_busy, cur_ovf;
  always_comb begin
    if (sel) begin
      cur_an = ib.anode_activate; cur_led = ib.LED_out;
      cur_busy = ib.busy;         cur_ovf = ib.overflow;
    end else begin
      cur_an = {4'hF, ia.anode_activate}; cur_led = ia.LED_out;
      cur_busy = ia.busy;                 cur_ovf = ia.overflow;
    end
  end

  task automatic chk(input longint obs, input longint exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_of(input longint d);
    case (d)
      0: return 7'b0000001; 1: return 7'b1001111; 2: return 7'b0010010;
      3: return 7'b0000110; 4: return 7'b1001100; 5: return 7'b0100100;
      6: return 7'b0100000; 7: return 7'b0001111; 8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [7:0] exp_led(input int nd, input longint val, input bit blz,
                                         input logic [7:0] dpm, input int k);
    logic [6:0] s;
    longint p = pow10(k);
    if (val >= pow10(nd))        s = 7'b1111110;
    else if (blz && k > 0 && val < p) s = 7'b1111111;
    else                         s = seg_of((val / p) % 10);
    return {s, ~dpm[k]};
  endfunction

  task automatic set_in(input longint v, input bit ld);
    if (!sel) begin ia.value = AW'(v); ia.value_load = ld; end
    else      begin ib.value = BW'(v); ib.value_load = ld; end
  endtask

  task automatic set_cfg(input bit blz, input logic [7:0] dpm);
    cfg_blz = blz; cfg_dpm = dpm;
    ia.blank_leading_zeros = blz; ia.dp_mask = dpm[3:0];
    ib.blank_leading_zeros = blz; ib.dp_mask = dpm;
  endtask

  // Load v; optionally pulse a second load of v2 at busy cycle pulse_at
  task automatic load(input longint v, input int pulse_at, input longint v2, input string tag);
    int n;
    int w  = sel ? BW : AW;
    int nd = sel ? BN : AN;
    @(negedge clock_100Mhz); set_in(v, 1'b1);
    @(negedge clock_100Mhz); set_in(v, 1'b0);
    n = 0;
    while (cur_busy && n < 200) begin
      n++;
      if (n == pulse_at) set_in(v2, 1'b1); else set_in(v, 1'b0);
      @(negedge clock_100Mhz);
    end
    set_in(v, 1'b0);
    chk(n, w + 1, {tag, "_busy_len"});
    chk(cur_ovf, (v >= pow10(nd)) ? 1 : 0, {tag, "_ovf"});
  endtask

  // Observe one full scan: digit order, pin patterns, active and blank lengths
  task automatic check_scan(input longint val, input string tag);
    int nd = sel ? BN : AN;
    int rd = sel ? BRD : ARD;
    int bc = sel ? BBC : ABC;
    int n, k, prev;
    logic [7:0] ean;
    n = 0;
    while (cur_an != 8'hFF && n < 4*rd) begin @(negedge clock_100Mhz); n++; end
    n = 0;
    while (cur_an == 8'hFF && n < 4*rd) begin @(negedge clock_100Mhz); n++; end
    prev = 0;
    for (int d = 0; d < nd; d++) begin
      if (d == 0) begin
        k = 0;
        for (int i = 0; i < nd; i++) if (!cur_an[i]) k = i;
      end else begin
        k = (prev == 0) ? nd - 1 : prev - 1;
      end
      ean = 8'hFF; ean[k] = 1'b0;
      chk(cur_an, ean, $sformatf("%s_anode_d%0d", tag, k));
      chk(cur_led, exp_led(nd, val, cfg_blz, cfg_dpm, k), $sformatf("%s_led_d%0d", tag, k));
      n = 0;
      while (cur_an == ean && n < 4*rd) begin @(negedge clock_100Mhz); n++; end
      chk(n, rd - bc, $sformatf("%s_active_len_d%0d", tag, k));
      n = 0;
      while (cur_an == 8'hFF && n < 4*rd) begin @(negedge clock_100Mhz); n++; end
      chk(n, bc, $sformatf("%s_blank_len_d%0d", tag, k));
      prev = k;
    end
  endtask

  initial begin
    longint v;
    ia.value = '0; ia.value_load = 1'b0;
    ib.value = '0; ib.value_load = 1'b0;
    set_cfg(1'b0, 8'h00);

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk(cur_busy, 0, "rst_busy");
    chk(cur_ovf, 0, "rst_ovf");
    chk(cur_an, 8'hFF, "rst_anode");
    chk(cur_led, 8'hFF, "rst_led");
    repeat (3) @(negedge clock_100Mhz);
    reset = 1'b1;

    // Basic conversion and scan
    load(1234, -1, 0, "v1234");
    check_scan(1234, "v1234");

    // Reset in the middle of a conversion
    @(negedge clock_100Mhz); set_in(4321, 1'b1);
    @(negedge clock_100Mhz); set_in(4321, 1'b0);
    repeat (5) @(negedge clock_100Mhz);
    #2 reset = 1'b0;
    #1;
    chk(cur_busy, 0, "midrst_busy");
    chk(cur_an, 8'hFF, "midrst_anode");
    chk(cur_led, 8'hFF, "midrst_led");
    @(negedge clock_100Mhz); reset = 1'b1;
    check_scan(0, "after_rst");

    // Overflow boundary
    load(9999, -1, 0, "v9999");
    check_scan(9999, "v9999");
    load(10000, -1, 0, "v10000");
    check_scan(10000, "v10000");
    load(42, -1, 0, "v42");
    check_scan(42, "v42");

    // Leading-zero blanking
    set_cfg(1'b1, 8'h00);
    load(7, -1, 0, "blz7");
    check_scan(7, "blz7");
    load(0, -1, 0, "blz0");
    check_scan(0, "blz0");

    // Load while busy is ignored
    set_cfg(1'b0, 8'h00);
    load(1111, 3, 5555, "ignore");
    check_scan(1111, "ignore");

    // Randomised values and live controls
    for (int r = 0; r < 6; r++) begin
      v = longint'($urandom_range(0, 65535));
      set_cfg(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
      load(v, -1, 0, $sformatf("rndA%0d", r));
      check_scan(v, $sformatf("rndA%0d", r));
    end

    // Wide instance
    sel = 1'b1;
    set_cfg(1'b0, 8'h04);
    load(99999999, -1, 0, "b_9s");
    check_scan(99999999, "b_9s");
    for (int r = 0; r < 3; r++) begin
      v = longint'($urandom_range(0, 134217727));
      set_cfg(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      load(v, -1, 0, $sformatf("rndB%0d", r));
      check_scan(v, $sformatf("rndB%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
